adj_arbiter: RTL and testbench

- Shares one normalisation/adjustment unit (start/done/recieved handshake) between two multiplier lanes.
- Round-robin grant; registers and holds the winning lane's operands for the whole unit transaction.
- Bypasses zero mantissas, which would never normalise and would hang the unit.
- Returns the adjusted result to the granted lane over a valid/ready response port.
- Sits between the lane mantissa-product stages and the posit encode stage.

---
 rtl/posit_adj_pkg.sv | 16 +
 rtl/adj_arbiter_rr_arb2.sv | 10 +
 rtl/adj_arbiter.sv | 170 +++++++++++++++++
 tb/tb_adj_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_adj_pkg.sv
// posit_adj_pkg: shared widths and controller state encoding for the adjustment arbiter
package posit_adj_pkg;
    localparam int E_W   = 10;
    localparam int M_W   = 64;
    localparam int EXP_W = 3;
    localparam int K_W   = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        DRAIN = 3'd4,
        RESP  = 3'd5
    } state_t;
endpackage

// File: rtl/adj_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant favouring the lane that did not win last
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       gnt,
    output logic       any
);
    assign any = |req_valid;
    assign gnt = (&req_valid) ? ~last_grant : req_valid[1];
endmodule

// File: rtl/adj_arbiter.sv
// adj_arbiter: shares one normalisation/adjustment unit between two multiplier lanes
module adj_arbiter
    import posit_adj_pkg::*;
#(
    parameter int TIMEOUT_CYC = 80,
    parameter int E_W         = posit_adj_pkg::E_W,
    parameter int M_W         = posit_adj_pkg::M_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [E_W-1:0]   req_E_raw0,
    input  logic [E_W-1:0]   req_E_raw1,
    input  logic [M_W-1:0]   req_mant0,
    input  logic [M_W-1:0]   req_mant1,
    input  logic [1:0]       req_sign,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [M_W-1:0]   rsp_mant,
    output logic [EXP_W-1:0] rsp_exp,
    output logic [K_W-1:0]   rsp_k,
    output logic             rsp_sign,
    output logic             rsp_zero,
    output logic             u_start,
    output logic [E_W-1:0]   u_E_raw,
    output logic [M_W-1:0]   u_mant_prod,
    output logic             u_sign,
    output logic             u_recieved,
    input  logic             u_done,
    input  logic [M_W-1:0]   u_mant_adj,
    input  logic [EXP_W-1:0] u_adj_exp,
    input  logic [K_W-1:0]   u_adj_k,
    input  logic             u_sign_out,
    output logic             err_timeout
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    state_t           state_q, state_d;
    logic             last_q, last_d, lane_q, lane_d, err_q, err_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [E_W-1:0]   e_q, e_d;
    logic [M_W-1:0]   m_q, m_d;
    logic             s_q, s_d;
    logic [M_W-1:0]   rm_q, rm_d;
    logic [EXP_W-1:0] rx_q, rx_d;
    logic [K_W-1:0]   rk_q, rk_d;
    logic             rs_q, rs_d, rz_q, rz_d;
    logic             gnt, any, acc;
    logic [E_W-1:0]   sel_e;
    logic [M_W-1:0]   sel_m;
    logic             sel_s;

    rr_arb2 u_arb (
        .req_valid  (req_valid),
        .last_grant (last_q),
        .gnt        (gnt),
        .any        (any)
    );

    assign acc         = (state_q == IDLE) && !err_q && any;
    assign req_ready   = acc ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid   = (state_q == RESP) ? (lane_q ? 2'b10 : 2'b01) : 2'b00;
    assign u_start     = (state_q == ISSUE);
    assign u_recieved  = (state_q == ACK);
    assign sel_e       = gnt ? req_E_raw1 : req_E_raw0;
    assign sel_m       = gnt ? req_mant1 : req_mant0;
    assign sel_s       = req_sign[gnt];
    assign u_E_raw     = e_q;
    assign u_mant_prod = m_q;
    assign u_sign      = s_q;
    assign rsp_mant    = rm_q;
    assign rsp_exp     = rx_q;
    assign rsp_k       = rk_q;
    assign rsp_sign    = rs_q;
    assign rsp_zero    = rz_q;
    assign err_timeout = err_q;

    // Controller and datapath registers; reset also abandons any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            lane_q  <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            e_q     <= '0;
            m_q     <= '0;
            s_q     <= 1'b0;
            rm_q    <= '0;
            rx_q    <= '0;
            rk_q    <= '0;
            rs_q    <= 1'b0;
            rz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            e_q     <= e_d;
            m_q     <= m_d;
            s_q     <= s_d;
            rm_q    <= rm_d;
            rx_q    <= rx_d;
            rk_q    <= rk_d;
            rs_q    <= rs_d;
            rz_q    <= rz_d;
        end
    end

    // Next state: accept, zero bypass, unit handshake with watchdog, response hold
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        lane_d  = lane_q;
        err_d   = err_q;
        wd_d    = wd_q;
        e_d     = e_q;
        m_d     = m_q;
        s_d     = s_q;
        rm_d    = rm_q;
        rx_d    = rx_q;
        rk_d    = rk_q;
        rs_d    = rs_q;
        rz_d    = rz_q;
        case (state_q)
            IDLE: if (acc) begin
                lane_d = gnt;
                last_d = gnt;
                e_d    = sel_e;
                m_d    = sel_m;
                s_d    = sel_s;
                if (sel_m == '0) begin
                    rm_d    = '0;
                    rx_d    = '0;
                    rk_d    = '0;
                    rs_d    = sel_s;
                    rz_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: if (u_done) begin
                rm_d    = u_mant_adj;
                rx_d    = u_adj_exp;
                rk_d    = u_adj_k;
                rs_d    = u_sign_out;
                rz_d    = 1'b0;
                wd_d    = '0;
                state_d = ACK;
            end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                err_d   = 1'b1;
                wd_d    = '0;
                state_d = IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
            ACK:   state_d = DRAIN;
            DRAIN: state_d = u_done ? DRAIN : RESP;
            RESP:  state_d = rsp_ready[lane_q] ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_adj_arbiter.sv
// tb_adj_arbiter: randomized scoreboard bench with a behavioural adjustment-unit model
module tb_adj_arbiter;
    localparam int TO = 80;

    typedef struct {
        logic        lane;
        logic [63:0] m;
        logic [2:0]  x;
        logic [5:0]  k;
        logic        s;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk, rst_n;
    logic [1:0]  req_valid, req_ready, req_sign, rsp_valid, rsp_ready;
    logic [9:0]  req_E_raw0, req_E_raw1, u_E_raw;
    logic [63:0] req_mant0, req_mant1, rsp_mant, u_mant_prod, u_mant_adj;
    logic [2:0]  rsp_exp, u_adj_exp;
    logic [5:0]  rsp_k, u_adj_k;
    logic        rsp_sign, rsp_zero, u_start, u_sign, u_recieved, u_done, u_sign_out, err_timeout;

    int   checks = 0, errors = 0, cyc = 0, rdy_mode = 1;
    logic track = 1'b1, hang = 1'b0;

    adj_arbiter #(.TIMEOUT_CYC(TO), .E_W(10), .M_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_E_raw0(req_E_raw0), .req_E_raw1(req_E_raw1),
        .req_mant0(req_mant0), .req_mant1(req_mant1), .req_sign(req_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_mant(rsp_mant), .rsp_exp(rsp_exp), .rsp_k(rsp_k),
        .rsp_sign(rsp_sign), .rsp_zero(rsp_zero),
        .u_start(u_start), .u_E_raw(u_E_raw), .u_mant_prod(u_mant_prod),
        .u_sign(u_sign), .u_recieved(u_recieved), .u_done(u_done),
        .u_mant_adj(u_mant_adj), .u_adj_exp(u_adj_exp), .u_adj_k(u_adj_k),
        .u_sign_out(u_sign_out), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Normalise so the leading one lands on bit 62; scale split as es=3 posit fields
    function automatic exp_t ref_rsp(input logic [9:0] e, input logic [63:0] m, input logic s);
        exp_t r;
        int p;
        logic [9:0] sc;
        r.lane = 1'b0; r.acc = 0; r.s = s; p = 0; sc = '0;
        if (m == 64'd0) begin
            r.m = '0; r.x = '0; r.k = '0; r.z = 1'b1; r.lat = 1;
            return r;
        end
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        if (p == 63) begin
            r.m = m >> 1; sc = e + 10'd1; r.lat = 9;
        end else begin
            r.m = m << (62 - p); sc = e - 10'(62 - p); r.lat = 8 + 62 - p;
        end
        r.x = sc[2:0]; r.k = sc[8:3]; r.z = 1'b0;
        return r;
    endfunction

    task automatic chk(input string n, input logic [191:0] got, input logic [191:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, got, want);
        end
    endtask

    // Adjustment unit model: multi-cycle normalise, done held until one cycle after recieved
    exp_t uc, ur;
    int   cnt;
    logic ub, ul, us;
    logic [9:0]  ue;
    logic [63:0] um;
    always_comb uc = ref_rsp(u_E_raw, u_mant_prod, u_sign);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ub <= 0; ul <= 0; cnt <= 0; u_done <= 0;
            u_mant_adj <= '0; u_adj_exp <= '0; u_adj_k <= '0; u_sign_out <= 0;
            ue <= '0; um <= '0; us <= 0;
        end else begin
            if (u_start && !ub && !u_done) begin
                ub <= 1; ue <= u_E_raw; um <= u_mant_prod; us <= u_sign;
                ur <= uc; cnt <= uc.lat - 7;
            end else if (ub && !hang) begin
                if (cnt == 0) begin
                    ub <= 0; u_done <= 1;
                    u_mant_adj <= ur.m; u_adj_exp <= ur.x; u_adj_k <= ur.k; u_sign_out <= u_sign;
                end else cnt <= cnt - 1;
            end
            if (u_done && u_recieved) ul <= 1;
            if (ul) begin ul <= 0; u_done <= 0; end
        end
    end

    always @(posedge clk) begin
        #1;
        rsp_ready = (rdy_mode == 0) ? 2'($urandom) : (rdy_mode == 1) ? 2'b11 : 2'b00;
    end

    // Monitor: reference arbitration model, scoreboard, latency/stability/handshake checks
    exp_t q[$];
    exp_t r, e, snap;
    logic m_busy, m_last, m_err, exp_start, seen, held, pl;
    logic [1:0] er;
    int   deadline;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_err = 0; exp_start = 0; seen = 0; held = 0;
            deadline = -1; q.delete();
        end else begin
            if (cyc == deadline) begin m_err = 1; m_busy = 0; deadline = -1; end
            pl = (&req_valid) ? ~m_last : req_valid[1];
            er = (!m_busy && !m_err && |req_valid) ? (pl ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", req_ready, er);
            chk("err_timeout", err_timeout, m_err);
            if (u_start) begin chk("start_ok", {u_done, exp_start}, 2'b01); exp_start = 0; end
            if (u_recieved) chk("operand_hold", {u_E_raw, u_mant_prod, u_sign}, {ue, um, us});
            if (rsp_valid != 2'b00) begin
                if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 2'b00);
                else begin
                    if (!seen) begin chk("latency", cyc - q[0].acc + 1, q[0].lat); seen = 1; end
                    else if (held) chk("rsp_stable", {rsp_valid, rsp_mant, rsp_exp, rsp_k, rsp_sign, rsp_zero},
                                       {snap.lane ? 2'b10 : 2'b01, snap.m, snap.x, snap.k, snap.s, snap.z});
                    if (|(rsp_valid & rsp_ready)) begin
                        e = q.pop_front();
                        chk("rsp", {rsp_valid, rsp_mant, rsp_exp, rsp_k, rsp_sign, rsp_zero},
                            {e.lane ? 2'b10 : 2'b01, e.m, e.x, e.k, e.s, e.z});
                        seen = 0; held = 0; m_busy = 0;
                    end else begin
                        held = 1;
                        snap.lane = rsp_valid[1]; snap.m = rsp_mant; snap.x = rsp_exp;
                        snap.k = rsp_k; snap.s = rsp_sign; snap.z = rsp_zero;
                    end
                end
            end
            if ((req_valid & req_ready) != 2'b00) begin
                m_busy = 1; m_last = pl;
                r = pl ? ref_rsp(req_E_raw1, req_mant1, req_sign[1]) : ref_rsp(req_E_raw0, req_mant0, req_sign[0]);
                r.lane = pl; r.acc = cyc + 1;
                exp_start = !r.z;
                if (hang) deadline = cyc + 1 + TO + 1;
                else if (track) q.push_back(r);
            end
        end
    end

    task automatic issue(input logic [1:0] mask, input logic [9:0] e0, input logic [9:0] e1,
                         input logic [63:0] m0, input logic [63:0] m1, input logic [1:0] s);
        logic [1:0] pend, got;
        int n;
        @(posedge clk); #1;
        req_E_raw0 = e0; req_E_raw1 = e1; req_mant0 = m0; req_mant1 = m1; req_sign = s;
        req_valid = mask; pend = mask; n = 0;
        while (pend != 2'b00 && n < 400) begin
            @(negedge clk);
            got = req_valid & req_ready;
            if (got != 2'b00) begin
                @(posedge clk); #1;
                pend = pend & ~got; req_valid = pend;
            end else n++;
        end
        if (pend != 2'b00) begin
            chk("accept_timeout", pend, 2'b00);
            req_valid = 2'b00;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || rsp_valid != 2'b00) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("drain_timeout", q.size(), 0);
    endtask

    function automatic logic [63:0] rnd_mant();
        logic [63:0] v;
        v = {$urandom, $urandom} >> $urandom_range(0, 20);
        return ($urandom_range(0, 4) == 0) ? 64'd0 : v;
    endfunction

    initial begin
        int n;
        rst_n = 0; req_valid = 0; req_sign = 0; rsp_ready = 0;
        req_E_raw0 = 0; req_E_raw1 = 0; req_mant0 = 0; req_mant1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {rsp_valid, req_ready, u_start, u_recieved, u_E_raw, u_mant_prod, u_sign,
                            rsp_mant, rsp_exp, rsp_k, rsp_sign, rsp_zero, err_timeout}, 0);
        rst_n = 1;
        issue(2'b11, 10'd0, 10'd7, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10);
        wait_drain();
        issue(2'b01, 10'd19, 10'd0, 64'h4000_0000_0000_0000, 64'd0, 2'b00);
        wait_drain();
        issue(2'b10, 10'd0, 10'd33, 64'd0, 64'd0, 2'b10);
        wait_drain();
        rdy_mode = 2;
        issue(2'b01, 10'd5, 10'd0, 64'h0000_0100_0000_0000, 64'd0, 2'b01);
        fork
            issue(2'b10, 10'd0, 10'd300, 64'd0, 64'h0000_0000_0000_1234, 2'b10);
            begin
                n = 0;
                while (rsp_valid == 2'b00 && n < 200) begin @(negedge clk); n++; end
                repeat (10) @(negedge clk);
                rdy_mode = 1;
            end
        join
        wait_drain();
        rdy_mode = 0;
        repeat (40) issue(2'($urandom_range(1, 3)), 10'($urandom), 10'($urandom),
                          rnd_mant(), rnd_mant(), 2'($urandom));
        wait_drain();
        rdy_mode = 1; hang = 1;
        issue(2'b01, 10'd3, 10'd0, 64'h4000_0000_0000_0000, 64'd0, 2'b00);
        repeat (90) @(negedge clk);
        @(posedge clk); #1 req_valid = 2'b11;
        repeat (10) @(negedge clk);
        chk("err_sticky", {err_timeout, req_ready}, 3'b100);
        @(posedge clk); #1 req_valid = 2'b00;
        hang = 0;
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        track = 0;
        issue(2'b01, 10'd9, 10'd0, 64'd1, 64'd0, 2'b01);
        repeat (6) @(posedge clk);
        #2 rst_n = 0;
        #1 chk("async_reset", {rsp_valid, req_ready, u_start, u_recieved, u_E_raw, u_mant_prod, u_sign,
                               rsp_mant, rsp_exp, rsp_k, rsp_sign, rsp_zero, err_timeout}, 0);
        @(posedge clk); #1 rst_n = 1;
        track = 1;
        issue(2'b11, 10'd12, 10'd40, 64'h2000_0000_0000_0000, 64'd0, 2'b11);
        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end
endmodule
